// File: rtl/orbit_wr_arbiter_pkg.sv
// Shared definitions for the orbit write-port arbiter: FSM state encoding,
// default orbit word/address widths and the burst counter width.
package orbit_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEFAULT_DW = 12;
    localparam int DEFAULT_AW = 10;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/orbit_wr_arbiter_if.sv
// Bus between the packers and the arbiter / group distributor write port.
//
// Handshake: a packer raises iReq[i] and holds it for its whole burst. It may
// only drive iWren[i] while oGnt[i] is high; the burst ends when the packer
// drops iReq[i] (or the watchdog cuts it). Writes from a packer that does not
// own the port are dropped and flagged on oCollision. oGnt is one-hot or zero.
interface orbit_wr_arbiter_if
    import orbit_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DEFAULT_DW,
    parameter int AW    = DEFAULT_AW
);
    logic [N_REQ-1:0]    iReq;
    logic [N_REQ*DW-1:0] iData;
    logic [N_REQ*AW-1:0] iAddr;
    logic [N_REQ-1:0]    iWren;
    logic                iBusy;
    logic [N_REQ-1:0]    oGnt;
    logic [DW-1:0]       oData;
    logic [AW-1:0]       oAddr;
    logic                oWren;
    logic                oBusy;
    logic                oTimeout;
    logic                oCollision;

    // Packer / LCB side
    modport master (
        output iReq, iData, iAddr, iWren, iBusy,
        input  oGnt, oData, oAddr, oWren, oBusy, oTimeout, oCollision
    );

    // Arbiter side
    modport slave (
        input  iReq, iData, iAddr, iWren, iBusy,
        output oGnt, oData, oAddr, oWren, oBusy, oTimeout, oCollision
    );
endinterface

// File: rtl/orbit_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first set bit of
// eligible scanning upward from (last+1) mod N_REQ, with wrap.
module rr_pick
    import orbit_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] pick,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Scan candidates last+1 .. last+N_REQ (mod N_REQ); first hit wins
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        pick     = '0;
        idx      = '0;
        valid    = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(last) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IW-1:0];
            if (!valid && eligible[cand_idx]) begin
                valid          = 1'b1;
                idx            = cand_idx;
                pick[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/orbit_wr_arbiter.sv
// Round-robin arbiter for the group-distributor write port. Grants one packer
// per burst while the LCBs are idle, forwards the owner's writes through a
// registered mux, cuts over-long bursts and flags writes from non-owners.
module orbit_wr_arbiter
    import orbit_wr_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DEFAULT_DW,
    parameter int AW      = DEFAULT_AW,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    orbit_wr_arbiter_if.slave  bus,
    output arb_state_e         dbg_state
);

    localparam int                IW        = $clog2(N_REQ);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [IW-1:0]     LAST_RST  = IW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wren_q, wren_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             collision_q, collision_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    assign eligible = bus.iReq & ~mask_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .eligible (eligible),
        .last     (last_q),
        .pick     (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // Next-state logic: FSM, burst watchdog, mask, write mux and sticky flags
    always_comb begin
        logic [N_REQ-1:0] own_bit;
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        data_d      = data_q;
        addr_d      = addr_q;
        wren_d      = 1'b0;
        timeout_d   = timeout_q;
        own_bit     = '0;
        // A packer that drops its request is forgiven for an earlier timeout
        mask_d      = mask_q & bus.iReq;

        if (state_q == ST_GRANT) begin
            own_bit[owner_q] = 1'b1;
        end
        collision_d = collision_q | (|(bus.iWren & ~own_bit));

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && !bus.iBusy) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    gnt_d   = pick_oh;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                // The owner's last write is forwarded even as iReq falls
                if (bus.iWren[owner_q]) begin
                    wren_d = 1'b1;
                    data_d = bus.iData[int'(owner_q)*DW +: DW];
                    addr_d = bus.iAddr[int'(owner_q)*AW +: AW];
                end
                if (!bus.iReq[owner_q]) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d          = ST_RELEASE;
                    gnt_d            = '0;
                    cnt_d            = '0;
                    timeout_d        = 1'b1;
                    mask_d[owner_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            mask_q      <= '0;
            gnt_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            collision_q <= collision_d;
        end
    end

    assign bus.oGnt       = gnt_q;
    assign bus.oData      = data_q;
    assign bus.oAddr      = addr_q;
    assign bus.oWren      = wren_q;
    assign bus.oBusy      = busy_q;
    assign bus.oTimeout   = timeout_q;
    assign bus.oCollision = collision_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_orbit_wr_arbiter.sv
// Directed bench for orbit_wr_arbiter (N_REQ=4, TIMEOUT=8). Inputs are driven
// 1 time unit after each rising edge and outputs are checked at that point.
module tb_orbit_wr_arbiter;
    import orbit_wr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int AW = 10;

    logic       clk;
    logic       reset;
    arb_state_e dbg_state;
    int         checks;
    int         failures;

    orbit_wr_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus_if ();

    orbit_wr_arbiter #(
        .N_REQ   (N),
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // Clock and global time bound
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.iReq  = '0;
        bus_if.iData = '0;
        bus_if.iAddr = '0;
        bus_if.iWren = '0;
        bus_if.iBusy = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        step();
        checks++; if (bus_if.oGnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", bus_if.oGnt); end
        checks++; if (bus_if.oWren !== 1'b0 || bus_if.oBusy !== 1'b0) begin failures++; $display("FAIL rst_wren_busy got=%b%b exp=00", bus_if.oWren, bus_if.oBusy); end
        checks++; if (bus_if.oTimeout !== 1'b0 || bus_if.oCollision !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", bus_if.oTimeout, bus_if.oCollision); end
        checks++; if (bus_if.oData !== 12'h000 || bus_if.oAddr !== 10'h000) begin failures++; $display("FAIL rst_data_addr got=%h/%h exp=000/000", bus_if.oData, bus_if.oAddr); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        reset = 1'b1;
        step();
        checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oBusy !== 1'b0) begin failures++; $display("FAIL idle_after_rst got=%b/%b exp=0000/0", bus_if.oGnt, bus_if.oBusy); end
    endtask

    task automatic test_single_write();
        bus_if.iReq = 4'b0001;
        bus_if.iData[1*DW +: DW] = 12'h111;
        bus_if.iAddr[1*AW +: AW] = 10'h111;
        step();
        checks++; if (bus_if.oGnt !== 4'b0001 || bus_if.oBusy !== 1'b1) begin failures++; $display("FAIL sw_grant got=%b/%b exp=0001/1", bus_if.oGnt, bus_if.oBusy); end
        checks++; if (bus_if.oWren !== 1'b0) begin failures++; $display("FAIL sw_wren_pre got=%b exp=0", bus_if.oWren); end
        bus_if.iWren = 4'b0001;
        bus_if.iData[0*DW +: DW] = 12'hABC;
        bus_if.iAddr[0*AW +: AW] = 10'h3FF;
        step();
        checks++; if (bus_if.oWren !== 1'b1 || bus_if.oData !== 12'hABC || bus_if.oAddr !== 10'h3FF) begin failures++; $display("FAIL sw_write got=%b %h %h exp=1 abc 3ff", bus_if.oWren, bus_if.oData, bus_if.oAddr); end
        bus_if.iWren = 4'b0000;
        bus_if.iReq  = 4'b0000;
        bus_if.iData[0*DW +: DW] = 12'h000;
        step();
        checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oWren !== 1'b0 || bus_if.oBusy !== 1'b1) begin failures++; $display("FAIL sw_release got=%b %b %b exp=0000 0 1", bus_if.oGnt, bus_if.oWren, bus_if.oBusy); end
        checks++; if (bus_if.oData !== 12'hABC || bus_if.oAddr !== 10'h3FF) begin failures++; $display("FAIL sw_hold got=%h %h exp=abc 3ff", bus_if.oData, bus_if.oAddr); end
        step();
        checks++; if (bus_if.oBusy !== 1'b0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL sw_idle got=%b %0d exp=0 %0d", bus_if.oBusy, dbg_state, ST_IDLE); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        pulse_reset();
        bus_if.iReq = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            exp_g = 4'b0001 << (b % 4);
            for (int c = 0; c < 3; c++) begin
                step();
                checks++; if (bus_if.oGnt !== exp_g || bus_if.oBusy !== 1'b1) begin failures++; $display("FAIL rr_grant b=%0d c=%0d got=%b/%b exp=%b/1", b, c, bus_if.oGnt, bus_if.oBusy, exp_g); end
            end
            bus_if.iReq = 4'b1111 & ~exp_g;
            step();
            checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oBusy !== 1'b1) begin failures++; $display("FAIL rr_release b=%0d got=%b/%b exp=0000/1", b, bus_if.oGnt, bus_if.oBusy); end
            bus_if.iReq = 4'b1111;
            step();
            checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oBusy !== 1'b0) begin failures++; $display("FAIL rr_gap b=%0d got=%b/%b exp=0000/0", b, bus_if.oGnt, bus_if.oBusy); end
        end
        bus_if.iReq = 4'b0000;
        step();
    endtask

    task automatic test_busy_hold();
        int bad;
        bad = 0;
        bus_if.iBusy = 1'b1;
        bus_if.iReq  = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.oGnt !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_hold granted_cycles got=%0d exp=0", bad); end
        bus_if.iBusy = 1'b0;
        step();
        checks++; if (bus_if.oGnt !== 4'b0100) begin failures++; $display("FAIL busy_release got=%b exp=0100", bus_if.oGnt); end
        bus_if.iReq = 4'b0000;
        step();
        step();
    endtask

    task automatic test_timeout();
        int gnt_cycles;
        gnt_cycles = 0;
        bus_if.iReq = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_if.oGnt === 4'b0100 && bus_if.oTimeout === 1'b0) gnt_cycles++;
            if (i == 1) bus_if.iReq = 4'b1100;
        end
        checks++; if (gnt_cycles != 8) begin failures++; $display("FAIL to_gnt_cycles got=%0d exp=8", gnt_cycles); end
        step();
        checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oTimeout !== 1'b1) begin failures++; $display("FAIL to_cut got=%b/%b exp=0000/1", bus_if.oGnt, bus_if.oTimeout); end
        step();
        step();
        checks++; if (bus_if.oGnt !== 4'b1000) begin failures++; $display("FAIL to_other_served got=%b exp=1000", bus_if.oGnt); end
        bus_if.iReq = 4'b0100;
        step();
        step();
        step();
        checks++; if (bus_if.oGnt !== 4'b0000 || bus_if.oBusy !== 1'b0) begin failures++; $display("FAIL to_masked got=%b/%b exp=0000/0", bus_if.oGnt, bus_if.oBusy); end
        bus_if.iReq = 4'b0000;
        step();
        bus_if.iReq = 4'b0100;
        step();
        checks++; if (bus_if.oGnt !== 4'b0100) begin failures++; $display("FAIL to_regrant got=%b exp=0100", bus_if.oGnt); end
        checks++; if (bus_if.oTimeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", bus_if.oTimeout); end
        bus_if.iReq = 4'b0000;
        step();
        step();
    endtask

    task automatic test_collision();
        bus_if.iReq = 4'b0001;
        step();
        checks++; if (bus_if.oGnt !== 4'b0001 || bus_if.oCollision !== 1'b0) begin failures++; $display("FAIL col_pre got=%b/%b exp=0001/0", bus_if.oGnt, bus_if.oCollision); end
        bus_if.iWren = 4'b0011;
        bus_if.iData[0*DW +: DW] = 12'h123;
        bus_if.iAddr[0*AW +: AW] = 10'h011;
        bus_if.iData[1*DW +: DW] = 12'h456;
        bus_if.iAddr[1*AW +: AW] = 10'h022;
        step();
        checks++; if (bus_if.oWren !== 1'b1 || bus_if.oData !== 12'h123 || bus_if.oAddr !== 10'h011) begin failures++; $display("FAIL col_owner_write got=%b %h %h exp=1 123 011", bus_if.oWren, bus_if.oData, bus_if.oAddr); end
        checks++; if (bus_if.oCollision !== 1'b1) begin failures++; $display("FAIL col_flag got=%b exp=1", bus_if.oCollision); end
        bus_if.iWren = 4'b0010;
        step();
        checks++; if (bus_if.oWren !== 1'b0 || bus_if.oData !== 12'h123 || bus_if.oAddr !== 10'h011) begin failures++; $display("FAIL col_dropped got=%b %h %h exp=0 123 011", bus_if.oWren, bus_if.oData, bus_if.oAddr); end
        clear_inputs();
        step();
        step();
        step();
        checks++; if (bus_if.oCollision !== 1'b1) begin failures++; $display("FAIL col_sticky got=%b exp=1", bus_if.oCollision); end
    endtask

    task automatic test_reset_mid_burst();
        bus_if.iReq = 4'b0010;
        step();
        checks++; if (bus_if.oGnt !== 4'b0010) begin failures++; $display("FAIL rmb_grant got=%b exp=0010", bus_if.oGnt); end
        bus_if.iWren = 4'b0010;
        bus_if.iData[1*DW +: DW] = 12'h5A5;
        bus_if.iAddr[1*AW +: AW] = 10'h155;
        step();
        checks++; if (bus_if.oWren !== 1'b1 || bus_if.oData !== 12'h5A5) begin failures++; $display("FAIL rmb_write got=%b %h exp=1 5a5", bus_if.oWren, bus_if.oData); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus_if.oWren !== 1'b0 || bus_if.oGnt !== 4'b0000 || bus_if.oBusy !== 1'b0) begin failures++; $display("FAIL rmb_async_out got=%b %b %b exp=0 0000 0", bus_if.oWren, bus_if.oGnt, bus_if.oBusy); end
        checks++; if (bus_if.oTimeout !== 1'b0 || bus_if.oCollision !== 1'b0) begin failures++; $display("FAIL rmb_async_flags got=%b%b exp=00", bus_if.oTimeout, bus_if.oCollision); end
        checks++; if (bus_if.oData !== 12'h000 || bus_if.oAddr !== 10'h000) begin failures++; $display("FAIL rmb_async_data got=%h %h exp=000 000", bus_if.oData, bus_if.oAddr); end
        step();
        clear_inputs();
        reset = 1'b1;
        bus_if.iReq = 4'b1111;
        step();
        checks++; if (bus_if.oGnt !== 4'b0001) begin failures++; $display("FAIL rmb_first_after_rst got=%b exp=0001", bus_if.oGnt); end
        bus_if.iReq = 4'b0000;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_busy_hold();
        test_timeout();
        test_collision();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
